// File: rtl/gate_timing_seq.sv
// Sequential core of the sync/gate timing generator: phase FSM plus the phase and frame down-counters.
// Registered state/cnt/cnt_len are exported for the downstream Sync/Gate/Done output logic.
module gate_timing_seq #(
    parameter int unsigned SYNC_W   = 8,
    parameter int unsigned GDEL_W   = 8,
    parameter int unsigned GATE_W   = 16,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned AUTO_RST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [SYNC_W-1:0] Tsync,
    input  logic [GDEL_W-1:0] Tgdel,
    input  logic [GATE_W-1:0] Tgate,
    input  logic [LEN_W-1:0]  Tlen,
    output logic [4:0]        state,
    output logic [CNT_W-1:0]  cnt,
    output logic [LEN_W-1:0]  cnt_len,
    output logic              Sync,
    output logic              Gate,
    output logic              Done
);

    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_SYNC = 5'b00010;
    localparam logic [4:0] S_GDEL = 5'b00100;
    localparam logic [4:0] S_GATE = 5'b01000;
    localparam logic [4:0] S_LEN  = 5'b10000;

    logic [4:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] tsync_x, tgdel_x, tgate_x;
    logic             legal, active, frame_end;

    assign tsync_x = CNT_W'(Tsync);
    assign tgdel_x = CNT_W'(Tgdel);
    assign tgate_x = CNT_W'(Tgate);

    always_comb begin
        legal = (state_q == S_IDLE) || (state_q == S_SYNC) || (state_q == S_GDEL) ||
                (state_q == S_GATE) || (state_q == S_LEN);
    end

    assign active    = legal && !state_q[0];
    // End of frame pre-empts whatever phase transition would otherwise happen.
    assign frame_end = active && (len_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        if (!legal) begin
            state_d = S_IDLE;
        end else if (ena) begin
            if (frame_end) begin
                done_d = 1'b1;
                cnt_d  = '0;
                if (AUTO_RST != 0) begin
                    state_d = S_SYNC;
                    cnt_d   = tsync_x;
                    len_d   = Tlen;
                end else begin
                    state_d = S_IDLE;
                end
            end else begin
                if (active) begin
                    len_d = len_q - LEN_W'(1);
                end
                case (state_q)
                    S_IDLE: begin
                        cnt_d   = tsync_x;
                        len_d   = Tlen;
                        state_d = S_SYNC;
                    end
                    S_SYNC: begin
                        if (cnt_q == '0) begin
                            cnt_d   = tgdel_x;
                            state_d = S_GDEL;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    S_GDEL: begin
                        if (cnt_q == '0) begin
                            cnt_d   = tgate_x;
                            state_d = S_GATE;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    S_GATE: begin
                        if (cnt_q == '0) begin
                            state_d = S_LEN;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    assign state   = state_q;
    assign cnt     = cnt_q;
    assign cnt_len = len_q;
    assign Sync    = state_q[1];
    assign Gate    = state_q[3];
    assign Done    = done_q;

endmodule

// File: tb/tb_gate_timing_seq.sv
// Bench for gate_timing_seq: two instances (AUTO_RST=0/1) checked every cycle against a frame-time model,
// plus literal expectations on the directed scenarios.
module tb_gate_timing_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [7:0]  tsync = '0;
    logic [7:0]  tgdel = '0;
    logic [15:0] tgate = '0;
    logic [15:0] tlen  = '0;

    logic [4:0]  st0, st1;
    logic [15:0] cnt0, cnt1, cl0, cl1;
    logic        sy0, sy1, ga0, ga1, dn0, dn1;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;
    bit          armed = 1'b0;

    gate_timing_seq #(.SYNC_W(8), .GDEL_W(8), .GATE_W(16), .LEN_W(16), .CNT_W(16), .AUTO_RST(0)) dut0 (
        .clk(clk), .rst(rst), .ena(ena), .Tsync(tsync), .Tgdel(tgdel), .Tgate(tgate), .Tlen(tlen),
        .state(st0), .cnt(cnt0), .cnt_len(cl0), .Sync(sy0), .Gate(ga0), .Done(dn0)
    );

    gate_timing_seq #(.SYNC_W(8), .GDEL_W(8), .GATE_W(16), .LEN_W(16), .CNT_W(16), .AUTO_RST(1)) dut1 (
        .clk(clk), .rst(rst), .ena(ena), .Tsync(tsync), .Tgdel(tgdel), .Tgate(tgate), .Tlen(tlen),
        .state(st1), .cnt(cnt1), .cnt_len(cl1), .Sync(sy1), .Gate(ga1), .Done(dn1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Model: a frame is described only by the number of enabled cycles since it began (t).
    bit          m_idle[2] = '{1'b1, 1'b1};
    bit          m_done[2] = '{1'b0, 1'b0};
    int unsigned m_t[2]    = '{0, 0};
    int unsigned m_ts[2]   = '{0, 0};
    int unsigned m_tg[2]   = '{0, 0};
    int unsigned m_tga[2]  = '{0, 0};
    int unsigned m_tl[2]   = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_idle[i] = 1'b1;
                m_t[i]    = 0;
                m_done[i] = 1'b0;
            end else if (!ena) begin
                m_done[i] = 1'b0;
            end else if (m_idle[i] || (i == 1 && m_t[i] == m_tl[i])) begin
                m_done[i] = !m_idle[i];
                m_idle[i] = 1'b0;
                m_t[i]    = 0;
                m_ts[i]   = tsync;
                m_tg[i]   = tgdel;
                m_tga[i]  = tgate;
                m_tl[i]   = tlen;
            end else if (m_t[i] == m_tl[i]) begin
                m_done[i] = 1'b1;
                m_idle[i] = 1'b1;
                m_t[i]    = 0;
            end else begin
                m_t[i]++;
                m_done[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [4:0]  es;
        logic [31:0] ec, el;
        int unsigned e1, e2, e3;
        string       p;
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                p  = (i == 0) ? "m0" : "m1";
                e1 = m_ts[i];
                e2 = e1 + 1 + m_tg[i];
                e3 = e2 + 1 + m_tga[i];
                if (m_idle[i]) begin
                    es = 5'b00001; ec = 0; el = 0;
                end else begin
                    el = m_tl[i] - m_t[i];
                    if (m_t[i] <= e1) begin
                        es = 5'b00010; ec = e1 - m_t[i];
                    end else if (m_t[i] <= e2) begin
                        es = 5'b00100; ec = e2 - m_t[i];
                    end else if (m_t[i] <= e3) begin
                        es = 5'b01000; ec = e3 - m_t[i];
                    end else begin
                        es = 5'b10000; ec = 0;
                    end
                end
                chk({p, ".state"},   (i == 0) ? 32'(st0)  : 32'(st1),  32'(es));
                chk({p, ".cnt"},     (i == 0) ? 32'(cnt0) : 32'(cnt1), ec);
                chk({p, ".cnt_len"}, (i == 0) ? 32'(cl0)  : 32'(cl1),  el);
                chk({p, ".Sync"},    (i == 0) ? 32'(sy0)  : 32'(sy1),  32'(es[1]));
                chk({p, ".Gate"},    (i == 0) ? 32'(ga0)  : 32'(ga1),  32'(es[3]));
                chk({p, ".Done"},    (i == 0) ? 32'(dn0)  : 32'(dn1),  32'(m_done[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset for one edge with the new timing inputs applied; the following cycle is cycle 0.
    task automatic start_test(input int unsigned ts, input int unsigned tg, input int unsigned tga,
                              input int unsigned tl);
        rst   = 1'b1;
        ena   = 1'b1;
        tsync = 8'(ts);
        tgdel = 8'(tg);
        tgate = 16'(tga);
        tlen  = 16'(tl);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        cyc   = 0;
        armed = 1'b1;
    endtask

    bit gseen;

    initial begin
        // Normal frame, and AUTO_RST restart on the second instance
        start_test(2, 1, 3, 12);
        chk("t1.rst_state", 32'(st0), 32'h01);
        chk("t1.rst_cnt", 32'(cnt0), 0);
        chk("t1.rst_cnt_len", 32'(cl0), 0);
        chk("t1.rst_done", 32'(dn0), 0);
        for (int c = 1; c <= 28; c++) begin
            step();
            if (cyc == 1 || cyc == 3) chk("t1.sync_on", 32'(sy0), 1);
            if (cyc == 1) chk("t1.cnt_load", 32'(cnt0), 2);
            if (cyc == 4) chk("t1.gdel", 32'(st0), 32'h04);
            if (cyc == 6 || cyc == 9) chk("t1.gate_on", 32'(ga0), 1);
            if (cyc == 10 || cyc == 13) chk("t1.len", 32'(st0), 32'h10);
            if (cyc == 13 || cyc == 15) chk("t1.done_off", 32'(dn0), 0);
            if (cyc == 14) begin
                chk("t1.done_on", 32'(dn0), 1);
                chk("t1.idle", 32'(st0), 32'h01);
                chk("t1.auto_done", 32'(dn1), 1);
                chk("t1.auto_sync", 32'(sy1), 1);
            end
            if (cyc == 26) chk("t1.auto_done_off", 32'(dn1), 0);
            if (cyc == 27) chk("t1.auto_done2", 32'(dn1), 1);
        end

        // Truncation in GDEL
        start_test(2, 1, 3, 4);
        gseen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (ga0 === 1'b1) gseen = 1'b1;
            if (cyc == 5) begin
                chk("t2.term_gdel", 32'(st0), 32'h04);
                chk("t2.term_len0", 32'(cl0), 0);
                chk("t2.done_off", 32'(dn0), 0);
            end
            if (cyc == 6) begin
                chk("t2.done_on", 32'(dn0), 1);
                chk("t2.idle", 32'(st0), 32'h01);
            end
        end
        chk("t2.gate_never", 32'(gseen), 0);

        // ena gap of 3 cycles during GATE
        start_test(2, 1, 3, 12);
        for (int c = 1; c <= 20; c++) begin
            step();
            if (cyc == 7) ena = 1'b0;
            if (cyc >= 7 && cyc <= 10) begin
                chk("t3.frz_state", 32'(st0), 32'h08);
                chk("t3.frz_gate", 32'(ga0), 1);
                chk("t3.frz_cnt", 32'(cnt0), 2);
                chk("t3.frz_len", 32'(cl0), 6);
                chk("t3.frz_done", 32'(dn0), 0);
            end
            if (cyc == 10) ena = 1'b1;
            if (cyc == 16) begin
                chk("t3.len", 32'(st0), 32'h10);
                chk("t3.done_off", 32'(dn0), 0);
            end
            if (cyc == 17) begin
                chk("t3.done_on", 32'(dn0), 1);
                chk("t3.idle", 32'(st0), 32'h01);
            end
        end

        // All-zero timing
        start_test(0, 0, 0, 0);
        for (int c = 1; c <= 4; c++) begin
            step();
            if (cyc == 1) chk("t4.sync", 32'(st0), 32'h02);
            if (cyc == 2) begin
                chk("t4.done_on", 32'(dn0), 1);
                chk("t4.idle", 32'(st0), 32'h01);
                chk("t4.auto_done", 32'(dn1), 1);
                chk("t4.auto_sync", 32'(sy1), 1);
            end
            if (cyc == 3) chk("t4.done_off", 32'(dn0), 0);
        end

        // Reset in the middle of SYNC
        start_test(2, 1, 3, 12);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (cyc == 2) begin
                chk("t5.pre_cnt", 32'(cnt0), 1);
                rst = 1'b1;
            end
            if (cyc == 3) begin
                chk("t5.state", 32'(st0), 32'h01);
                chk("t5.cnt", 32'(cnt0), 0);
                chk("t5.cnt_len", 32'(cl0), 0);
                chk("t5.done", 32'(dn0), 0);
                chk("t5.auto_done", 32'(dn1), 0);
                rst = 1'b0;
            end
        end

        // Wide SYNC with zero-length GDEL/GATE
        start_test(255, 0, 0, 300);
        for (int c = 1; c <= 305; c++) begin
            step();
            if (cyc == 1) begin
                chk("t6.cnt_load", 32'(cnt0), 255);
                chk("t6.len_load", 32'(cl0), 300);
            end
            if (cyc == 256) chk("t6.sync_end", 32'(st0), 32'h02);
            if (cyc == 257) chk("t6.gdel", 32'(st0), 32'h04);
            if (cyc == 258) chk("t6.gate", 32'(st0), 32'h08);
            if (cyc == 259) chk("t6.len", 32'(st0), 32'h10);
            if (cyc == 302) chk("t6.done_on", 32'(dn0), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
